// File: rtl/counter_slot_arbiter.sv
// counter_slot_arbiter: round-robin arbiter that shares one interval counter among NUM_REQ requesters
//   clk          posedge clock
//   reset_n      synchronous active-low reset
//   req_valid    per-requester interval request
//   req_count    packed interval lengths, slice i belongs to requester i
//   req_ready    one-hot accept strobe (only in IDLE)
//   abort        cancels the running interval
//   done_valid   completion report pending
//   done_ready   consumer accepts the report
//   done_id      requester index of the reported interval
//   done_aborted report is for an aborted interval
//   busy         an interval is running or its report is pending
//   count_out    current counter value
module counter_slot_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*CNT_W-1:0] req_count,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     abort,
  output logic                     done_valid,
  input  logic                     done_ready,
  output logic [IDX_W-1:0]         done_id,
  output logic                     done_aborted,
  output logic                     busy,
  output logic [CNT_W-1:0]         count_out
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt, r_target, w_req_cnt;
  logic [IDX_W-1:0]   r_grant_id, r_last_grant, w_sel, w_j;
  logic               r_aborted, w_any, w_accept;
  // rotating priority search starting just after the last granted requester
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_j   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_j = IDX_W'((int'(r_last_grant) + k) % NUM_REQ);
      if (!w_any && req_valid[w_j]) begin
        w_any = 1'b1;
        w_sel = w_j;
      end
    end
  end
  assign w_req_cnt = req_count[w_sel*CNT_W +: CNT_W];
  assign w_accept  = (r_state == S_IDLE) && w_any;
  // gated by reset so every output reads zero while reset is held
  assign req_ready = (reset_n && w_accept) ? (NUM_REQ'(1) << w_sel) : '0;
  // the final RUN cycle is the one where the counter sits at target-1; abort takes priority
  always_comb begin
    w_next = (r_state == S_IDLE) ? (w_any ? ((w_req_cnt == '0) ? S_DONE : S_RUN) : S_IDLE)
           : (r_state == S_RUN)  ? ((abort || r_cnt == r_target - CNT_W'(1)) ? S_DONE : S_RUN)
           : (r_state == S_DONE) ? (done_ready ? S_IDLE : S_DONE)
           : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_target     <= '0;
      r_grant_id   <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_aborted    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_target     <= w_req_cnt;
        r_grant_id   <= w_sel;
        r_last_grant <= w_sel;
        r_cnt        <= '0;
      end
      // counting stops on leaving RUN, so the counter lands exactly on target and never wraps
      if (r_state == S_RUN && !abort) r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == S_RUN && abort) r_aborted <= 1'b1;
      if (r_state == S_DONE && done_ready) r_aborted <= 1'b0;
    end
  end
  assign done_valid   = (r_state == S_DONE);
  assign done_id      = r_grant_id;
  assign done_aborted = r_aborted;
  assign busy         = (r_state != S_IDLE);
  assign count_out    = r_cnt;
endmodule
